instr_fetch_mem: RTL and testbench

Parametrised, pipelined instruction memory for the MIPS fetch stage. It replaces the bare PC-to-word block RAM lookup with the following:
- a valid/ready request/response handshake;
- a 3-entry response buffer, so fetch stalls never lose a word;
- a flush for branch/exception redirect;
- address-fault detection;
- a program-load write port.

It sits between the PC register and the IF/ID pipeline register.

---
 rtl/instr_fetch_mem.sv | 129 ++++++++++++
 tb/tb_instr_fetch_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// Pipelined instruction memory for the fetch stage: valid/ready handshake, 3-deep
// response buffer, flush on redirect, address-fault tagging and a program-load write port.
module instr_fetch_mem #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_3000,
  parameter int          ADDR_W       = 12,
  parameter int          DATA_W       = 32,
  parameter string       INIT_FILE    = "code.txt",
  parameter string       HANDLER_FILE = "code_handler.txt",
  parameter int          HANDLER_WORD = 1120
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic [31:0]       req_pc_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_instr_o,
  output logic [31:0]       rsp_pc_o,
  output logic [1:0]        rsp_exc_o,
  input  logic              flush_i,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  logic [29:0]       off_w;
  logic              mis, oor, accept;
  logic [1:0]        exc_d;
  logic [ADDR_W-1:0] idx;

  assign off_w  = 30'((req_pc_i - BASE_ADDR) >> 2);
  assign mis    = (req_pc_i[1:0] != 2'b00);
  assign oor    = (req_pc_i < BASE_ADDR) || (off_w[29:ADDR_W] != '0);
  assign exc_d  = mis ? 2'b01 : (oor ? 2'b10 : 2'b00);
  assign idx    = off_w[ADDR_W-1:0];
  assign accept = req_valid_i && req_ready_o;

  // Nonblocking write and read in one block gives read-first behaviour on a collision.
  always_ff @(posedge clk_i) begin
    if (load_we_i) mem[load_addr_i] <= load_data_i;
    if (accept)    rd_q <= mem[idx];
  end

  logic              inf_vld_q;
  logic [31:0]       inf_pc_q;
  logic [1:0]        inf_exc_q;
  logic [DATA_W-1:0] inf_instr;

  logic [DATA_W-1:0] fifo_instr_q [3];
  logic [31:0]       fifo_pc_q    [3];
  logic [1:0]        fifo_exc_q   [3];
  logic [1:0]        rd_ptr_q, wr_ptr_q, cnt_q, cnt_d;
  logic [2:0]        occ;
  logic              fifo_empty, pop, byp, fpop, push;

  assign inf_instr  = (inf_exc_q != 2'b00) ? '0 : rd_q;
  assign fifo_empty = (cnt_q == 2'd0);
  assign occ        = {1'b0, cnt_q} + {2'b00, inf_vld_q};
  assign req_ready_o = (occ < 3'd3);

  // With the FIFO empty the in-flight entry is the head, giving one-cycle latency.
  assign rsp_valid_o = !fifo_empty || inf_vld_q;
  assign pop  = rsp_valid_o && rsp_ready_i;
  assign byp  = pop && fifo_empty;
  assign fpop = pop && !fifo_empty;
  assign push = inf_vld_q && !byp;

  assign rsp_instr_o = !rsp_valid_o ? '0 : (fifo_empty ? inf_instr : fifo_instr_q[rd_ptr_q]);
  assign rsp_pc_o    = !rsp_valid_o ? '0 : (fifo_empty ? inf_pc_q  : fifo_pc_q[rd_ptr_q]);
  assign rsp_exc_o   = !rsp_valid_o ? '0 : (fifo_empty ? inf_exc_q : fifo_exc_q[rd_ptr_q]);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    case ({push, fpop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      inf_vld_q <= 1'b0;
      inf_pc_q  <= '0;
      inf_exc_q <= '0;
    end else begin
      inf_vld_q <= accept;
      if (accept) begin
        inf_pc_q  <= req_pc_i;
        inf_exc_q <= exc_d;
      end
      if (flush_i) begin
        cnt_q    <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (fpop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= inf_instr;
      fifo_pc_q[wr_ptr_q]    <= inf_pc_q;
      fifo_exc_q[wr_ptr_q]   <= inf_exc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: stimulus pushes expected responses, a
// negedge monitor pops and compares every response the consumer takes.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic [1:0]  rsp_exc;
  logic        flush = 1'b0;
  logic        load_we = 1'b0;
  logic [11:0] load_addr = '0;
  logic [31:0] load_data = '0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  exc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [31:0] pcs   [4] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
  logic [31:0] words [4] = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};

  instr_fetch_mem #(
    .BASE_ADDR(32'h0000_3000), .ADDR_W(12), .DATA_W(32),
    .INIT_FILE(""), .HANDLER_FILE(""), .HANDLER_WORD(1120)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_pc_i(req_pc), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_instr_o(rsp_instr), .rsp_pc_o(rsp_pc), .rsp_exc_o(rsp_exc),
    .flush_i(flush),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp: got pc %h instr %h exc %b, required no response",
                 rsp_pc, rsp_instr, rsp_exc);
      end else begin
        mon_e = exp_q.pop_front();
        if (rsp_pc !== mon_e.pc || rsp_exc !== mon_e.exc || rsp_instr !== mon_e.instr) begin
          failures++;
          $display("FAIL rsp_compare: got pc %h exc %b instr %h, required pc %h exc %b instr %h",
                   rsp_pc, rsp_exc, rsp_instr, mon_e.pc, mon_e.exc, mon_e.instr);
        end
      end
    end
  end

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    load_we = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [1:0] exc, input logic [31:0] instr);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_pc = pc;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: req_ready got 0 required 1 for pc %h", pc);
    end else begin
      exp_q.push_back({pc, exc, instr});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int k;
    int n;

    // Program image written through the load port while reset is held.
    load(12'd0, words[0]);
    load(12'd1, words[1]);
    load(12'd2, words[2]);
    load(12'd3, words[3]);
    load(12'd5, 32'h5555_5555);
    load(12'd1120, 32'h4180_CAFE);
    load(12'd4095, 32'h0FFF_0FFF);

    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    chk("rst_rsp_pc", rsp_pc, 32'd0);
    chk("rst_rsp_exc", {30'b0, rsp_exc}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Single fetch, one-cycle latency
    send(32'h3000, 2'b00, words[0]);
    @(negedge clk);
    chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back streaming
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_pc = pcs[i];
      @(negedge clk);
      chk("t2_req_ready", {31'b0, req_ready}, 32'd1);
      if (i > 0) chk("t2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      if (req_ready) exp_q.push_back({pcs[i], 2'b00, words[i]});
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("t2_rsp_valid_last", {31'b0, rsp_valid}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_idle", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;

    // Backpressure: only three requests fit
    rsp_ready = 1'b0;
    acc = 0;
    k = 0;
    req_valid = 1'b1;
    req_pc = pcs[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back({pcs[k % 4], 2'b00, words[k % 4]});
        acc++;
        @(posedge clk); #1;
        k++;
        req_pc = pcs[k % 4];
      end else begin
        @(posedge clk); #1;
      end
    end
    chk("t3_accepted", 32'(acc), 32'd3);
    @(negedge clk);
    chk("t3_req_ready_low", {31'b0, req_ready}, 32'd0);
    chk("t3_hold_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t3_hold_pc", rsp_pc, 32'h3000);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_drained_valid", {31'b0, rsp_valid}, 32'd0);
    chk("t3_req_ready_back", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Address faults and the last in-range word
    send(32'h3002, 2'b01, 32'h0);
    send(32'h2FFC, 2'b10, 32'h0);
    send(32'h7000, 2'b10, 32'h0);
    send(32'h2FFE, 2'b01, 32'h0);
    send(32'h6FFC, 2'b00, 32'h0FFF_0FFF);
    repeat (2) @(posedge clk);
    #1;

    // Flush with two responses buffered, redirect to the handler
    rsp_ready = 1'b0;
    send(32'h3000, 2'b00, words[0]);
    send(32'h3004, 2'b00, words[1]);
    flush = 1'b1;
    req_valid = 1'b1;
    req_pc = 32'h4180;
    exp_q.delete();
    exp_q.push_back({32'h4180, 2'b00, 32'h4180_CAFE});
    @(negedge clk);
    chk("t5_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("t5_rsp_pc", rsp_pc, 32'h4180);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_no_stale", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;

    // Load port: same-cycle read returns the old word, later read the new one
    load_we = 1'b1;
    load_addr = 12'd5;
    load_data = 32'hDEAD_BEEF;
    send(32'h3014, 2'b00, 32'h5555_5555);
    load_we = 1'b0;
    send(32'h3014, 2'b00, 32'hDEAD_BEEF);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
